// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - responder FSM state encoding
//   - word / byte-enable widths
//   - dmem_addr_ok(): a request is legal when it is word aligned and its
//     word index lies inside the array
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  function automatic logic dmem_addr_ok(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] widx;
    widx = {2'b00, addr[31:2]};
    return (addr[1:0] == 2'b00) && (widx < depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channels between the core's load/store
// path (master) and the data-memory responder (slave).
//   req_valid/req_ready  request handshake, req_we/addr/be/wdata payload
//   rsp_valid/rsp_ready  response handshake, rsp_rdata/rsp_err payload
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [31:0]            req_addr;
  logic [DMEM_BE_W-1:0]   req_be;
  logic [DMEM_WORD_W-1:0] req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DMEM_WORD_W-1:0] rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_sram_array.sv
// dmem_sram_array: single-port DEPTH x 32 storage with per-byte write enables
// and a synchronous read register. Storage contents are never reset; only the
// read register is.
//   clk, rst   clock, async active-high reset (read register only)
//   en_i       access strobe for this cycle
//   we_i       1 = write enabled bytes, 0 = read word into rdata_o
//   be_i       byte enables (bit i -> byte i)
//   addr_i     word index
//   wdata_i    write data
//   rdata_o    word read on the last read access, held until the next one
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [DMEM_BE_W-1:0]   be_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [DMEM_WORD_W-1:0] wdata_i,
  output logic [DMEM_WORD_W-1:0] rdata_o
);

  logic [DMEM_WORD_W-1:0] mem [DEPTH];
  logic [DMEM_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int i = 0; i < DMEM_BE_W; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rdata_q <= '0;
    else if (en_i && !we_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with programmable wait states.
//   clk, rst           clock, async active-high reset
//   bus (slave)        request / response channels, see dmem_responder_if
//   rd_count/wr_count  completed non-error loads / stores (DMEM_ACCESS_CNT_EN only)
// Optional feature macro: DMEM_ACCESS_CNT_EN adds the access counters.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// WAIT  | request captured, down-counting wait states
// RESP  | response valid and held until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_e            state_q;
  logic [3:0]             count_q;
  logic                   we_q;
  logic [31:0]            addr_q;
  logic [DMEM_BE_W-1:0]   be_q;
  logic [DMEM_WORD_W-1:0] wdata_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic                   rsp_load_q;

  logic                   accept;
  logic                   enter_resp;
  logic                   rsp_hs;
  logic                   cur_we;
  logic [31:0]            cur_addr;
  logic [DMEM_BE_W-1:0]   cur_be;
  logic [DMEM_WORD_W-1:0] cur_wdata;
  logic                   cur_ok;
  logic [DMEM_WORD_W-1:0] sram_rdata;

  assign accept = req_ready_q && bus.req_valid;
  assign rsp_hs = rsp_valid_q && bus.rsp_ready;

  // With zero wait states the RAM is accessed on the accept edge itself,
  // before the capture registers hold the request, so take the live inputs.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_be    = be_q;
    cur_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_be    = bus.req_be;
      cur_wdata = bus.req_wdata;
    end
  end

  assign cur_ok     = dmem_addr_ok(cur_addr, DEPTH);
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == ST_WAIT) && (count_q == 4'd1));

  dmem_sram_array #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk     (clk),
    .rst     (rst),
    .en_i    (enter_resp && cur_ok),
    .we_i    (cur_we),
    .be_i    (cur_be),
    .addr_i  (cur_addr[AW+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            be_q        <= bus.req_be;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= ST_WAIT;
            count_q     <= WAIT_INIT;
          end
        end
        ST_WAIT: count_q <= count_q - 4'd1;
        ST_RESP: begin
          if (rsp_hs) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
      // Overrides the IDLE/WAIT branch on the edge the RAM is accessed.
      if (enter_resp) begin
        state_q     <= ST_RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !cur_ok;
        rsp_load_q  <= !cur_we && cur_ok;
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  // The read register only updates on the RESP entry edge, so this stays
  // stable for the whole response; stores and errors report zero.
  assign bus.rsp_rdata = rsp_load_q ? sram_rdata : '0;

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (rsp_hs && !rsp_err_q) begin
      if (we_q) wr_count_q <= wr_count_q + 32'd1;
      else      rd_count_q <= rd_count_q + 32'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
